// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, reset PC, NOP encoding and register-field positions.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned RS1_HI    = 19;
  localparam int unsigned RS1_LO    = 15;
  localparam int unsigned RS2_HI    = 24;
  localparam int unsigned RS2_LO    = 20;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter flop with next-PC selection: word-aligned redirect target, +4, or hold.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {target_i[XLEN-1:2], 2'b00};
    end else if (!hold_i) begin
      // Natural modulo-2^XLEN wrap
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC, IF/ID pipeline register, register-address taps and a saturating
// stall-cycle counter for debug readout.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC[XLEN-1:0],
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic            pc_hold;
  logic            pc_redirect;
  logic [XLEN-1:0] if_id_pc_d, if_id_pc_q;
  logic [31:0]     if_id_instr_d, if_id_instr_q;
  logic            if_id_valid_d, if_id_valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Halt outranks flush, flush outranks stall
  assign pc_hold     = !start_i || stall_i;
  assign pc_redirect = start_i && flush_i;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hold_i     (pc_hold),
    .redirect_i (pc_redirect),
    .target_i   (branch_target_i),
    .pc_o       (pc_o)
  );

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    stall_cnt_d   = stall_cnt_q;
    if (!start_i) begin
      if_id_valid_d = 1'b0;
    end else if (flush_i) begin
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (stall_i) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      if_id_pc_d    = pc_o;
      if_id_instr_d = instr_i;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign rs1_addr_o    = if_id_instr_q[RS1_HI:RS1_LO];
  assign rs2_addr_o    = if_id_instr_q[RS2_HI:RS2_LO];
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized and directed bench for if_id_stage against a cycle-level behavioural model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, flush;
  logic [31:0] target;
  logic [31:0] instr;
  logic [31:0] pc, if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  rs1, rs2;
  logic [15:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (target),
    .instr_i         (instr),
    .pc_o            (pc),
    .if_id_pc_o      (if_id_pc),
    .if_id_instr_o   (if_id_instr),
    .if_id_valid_o   (if_id_valid),
    .rs1_addr_o      (rs1),
    .rs2_addr_o      (rs2),
    .stall_cnt_o     (stall_cnt)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Combinational instruction memory
  assign instr = imem(pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] iw;
    iw = m_instr;
    check({tag, ".pc"},       pc,                 m_pc);
    check({tag, ".if_pc"},    if_id_pc,           m_ifpc);
    check({tag, ".if_instr"}, if_id_instr,        m_instr);
    check({tag, ".valid"},    {31'b0, if_id_valid}, {31'b0, m_valid});
    check({tag, ".rs1"},      {27'b0, rs1},       {27'b0, iw[19:15]});
    check({tag, ".rs2"},      {27'b0, rs2},       {27'b0, iw[24:20]});
    check({tag, ".cnt"},      {16'b0, stall_cnt}, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the rules: halt > flush > stall > advance
  task automatic model_step(input logic st, input logic fl, input logic sl,
                            input logic [31:0] tg);
    if (!st) begin
      m_valid = 1'b0;
    end else if (fl) begin
      m_pc = tg & 32'hFFFF_FFFC; m_ifpc = 0; m_instr = 0; m_valid = 1'b0;
    end else if (sl) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_ifpc = m_pc; m_instr = imem(m_pc); m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  // Called just after a falling edge; leaves just after the next falling edge
  task automatic cycle(input string tag, input logic st, input logic fl, input logic sl,
                       input logic [31:0] tg, input bit chk);
    start = st; flush = fl; stall = sl; target = tg;
    @(posedge clk);
    model_step(st, fl, sl, tg);
    #1;
    if (chk) compare_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Straight-line fetch
    for (int i = 0; i < 4; i++) cycle("straight", 1, 0, 0, 0, 1);
    check("straight.pc16", pc, 32'd16);

    // Load-use stall at pc=8
    rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
    cycle("adv", 1, 0, 0, 0, 1);
    cycle("adv", 1, 0, 0, 0, 1);
    cycle("stall", 1, 0, 1, 0, 1);
    cycle("stall", 1, 0, 1, 0, 1);
    check("stall.cnt2", {16'b0, stall_cnt}, 32'd2);
    check("stall.pc8", pc, 32'd8);
    cycle("resume", 1, 0, 0, 0, 1);
    check("resume.ifpc8", if_id_pc, 32'd8);

    // Branch redirect to misaligned target
    cycle("branch", 1, 1, 0, 32'h103, 1);
    check("branch.pc", pc, 32'h100);
    cycle("branch.next", 1, 0, 0, 0, 1);
    check("branch.ifpc", if_id_pc, 32'h100);

    // Flush and stall together
    cycle("flush_stall", 1, 1, 1, 32'h200, 1);

    // PC wrap
    cycle("wrap.set", 1, 1, 0, 32'hFFFF_FFFF, 1);
    cycle("wrap.adv", 1, 0, 0, 0, 1);
    check("wrap.pc0", pc, 32'h0);

    // Halt for 3 cycles
    for (int i = 0; i < 3; i++) cycle("halt", 0, 0, 0, 0, 1);
    cycle("halt.resume", 1, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 3) == 0), $urandom, 1);
    end

    // Asynchronous reset between edges
    #2; rst = 1'b1; #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk); rst = 1'b0;
    cycle("post_rst", 1, 0, 0, 0, 1);

    // Drive the counter into saturation
    for (int i = 0; i < 65540; i++) cycle("sat", 1, 0, 1, 0, 0);
    compare_all("sat");
    check("sat.ffff", {16'b0, stall_cnt}, 32'h0000_FFFF);
    cycle("sat.more", 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle("sat.halt", 0, 0, 1, 0, 1);
    cycle("sat.adv", 1, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
